// File: rtl/tmss_bus_ctrl.sv
// tmss_bus_ctrl - 68000-side bus sequencer and security controller for TMSS.
// Decodes the TMSS register window (key, bank) and the boot-ROM window, answers
// them with a fixed-latency DTACK, sequences synchronous boot-ROM reads and runs
// the "SEGA" key unlock / VDP lockout state machine.
//
// Ports:
//   MCLK, SRES          clock, async active-high reset
//   AS, UDS, LDS, RW    68000 strobes (active low, RW=1 read)
//   VA, VD_i            CPU word address, write data
//   JAP                 1 = TMSS enforced
//   ROM_DATA            boot ROM data, valid one MCLK after ROM_RD
//   VD_o, data_out_en   registered read data and its bus drive enable
//   DTACK               active-low acknowledge
//   ROM_ADDR, ROM_RD    boot ROM word address and one-cycle read strobe
//   ROM_SEL             boot ROM mapped at 000000
//   VDP_LOCK, sec_state lockout flag and security state (debug)
module tmss_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] KEY         = 32'h53454741
) (
  input  logic        MCLK,
  input  logic        SRES,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [22:0] VA,
  input  logic [15:0] VD_i,
  input  logic        JAP,
  input  logic [15:0] ROM_DATA,
  output logic [15:0] VD_o,
  output logic        data_out_en,
  output logic        DTACK,
  output logic [9:0]  ROM_ADDR,
  output logic        ROM_RD,
  output logic        ROM_SEL,
  output logic        VDP_LOCK,
  output logic [1:0]  sec_state
);

  typedef enum logic [2:0] {B_IDLE, B_DECODE, B_READ_ROM, B_WAIT, B_ACK} bus_t;
  typedef enum logic [1:0] {S_LOCKED = 2'd0, S_UNLOCKED = 2'd1, S_LOCKOUT = 2'd2} sec_t;
  typedef enum logic [2:0] {T_NONE, T_KEYH, T_KEYL, T_BANK, T_BROM} tgt_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  bus_t        bus, bus_nxt;
  sec_t        sec, sec_nxt;
  tgt_t        tgt, dec_tgt;
  logic        rw_q, word_q;
  logic [3:0]  cnt;
  logic [31:0] key, key_nxt;
  logic        bank, bank_nxt;
  logic        is_vdp, commit;
  logic [15:0] reg_rdata;

  assign ROM_SEL     = JAP & ~bank;
  assign VDP_LOCK    = (sec == S_LOCKOUT);
  assign sec_state   = sec;
  assign DTACK       = ~(bus == B_ACK);
  assign data_out_en = (bus == B_ACK) & rw_q;

  // Address decode, only meaningful while in DECODE. Boot-ROM writes are not
  // claimed; the ROM is read-only.
  assign is_vdp = (VA[22:20] == 3'b110);
  always_comb begin
    dec_tgt = T_NONE;
    if (VA == 23'h50A000)                       dec_tgt = T_KEYH;
    else if (VA == 23'h50A001)                  dec_tgt = T_KEYL;
    else if (VA == 23'h50A080 && !LDS)          dec_tgt = T_BANK;
    else if (VA[22:10] == 13'd0 && ROM_SEL && RW) dec_tgt = T_BROM;
  end

  always_comb begin
    reg_rdata = 16'h0000;
    case (dec_tgt)
      T_KEYH:  reg_rdata = key[31:16];
      T_KEYL:  reg_rdata = key[15:0];
      T_BANK:  reg_rdata = {15'd0, bank};
      default: reg_rdata = 16'h0000;
    endcase
  end

  // Bus FSM
  always_ff @(posedge MCLK or posedge SRES) begin
    if (SRES) bus <= B_IDLE;
    else      bus <= bus_nxt;
  end

  always_comb begin
    bus_nxt = bus;
    case (bus)
      B_IDLE:     if (!AS) bus_nxt = B_DECODE;
      B_DECODE: begin
        if (AS)                   bus_nxt = B_IDLE;
        else if (dec_tgt == T_BROM) bus_nxt = B_READ_ROM;
        else if (dec_tgt != T_NONE) bus_nxt = B_WAIT;
        else                      bus_nxt = B_IDLE;
      end
      B_READ_ROM: bus_nxt = AS ? B_IDLE : B_WAIT;
      B_WAIT: begin
        if (AS)             bus_nxt = B_IDLE;
        else if (cnt == 4'd0) bus_nxt = B_ACK;
      end
      B_ACK:      if (AS) bus_nxt = B_IDLE;
      default:    bus_nxt = B_IDLE;
    endcase
  end

  // Writes land on the edge that enters ACK; an aborted cycle never gets here.
  assign commit = (bus == B_WAIT) && (bus_nxt == B_ACK) && !rw_q;

  always_comb begin
    key_nxt  = key;
    bank_nxt = bank;
    sec_nxt  = sec;
    if (commit && word_q && tgt == T_KEYH) key_nxt[31:16] = VD_i;
    if (commit && word_q && tgt == T_KEYL) key_nxt[15:0]  = VD_i;
    if (commit && tgt == T_BANK)           bank_nxt       = VD_i[0];
    // Lockout uses the security state as it stands during DECODE.
    if (bus == B_DECODE && is_vdp && JAP && sec == S_LOCKED)
      sec_nxt = S_LOCKOUT;
    else if (commit && word_q && (tgt == T_KEYH || tgt == T_KEYL) && sec != S_LOCKOUT)
      sec_nxt = (key_nxt == KEY) ? S_UNLOCKED : S_LOCKED;
  end

  always_ff @(posedge MCLK or posedge SRES) begin
    if (SRES) begin
      tgt      <= T_NONE;
      rw_q     <= 1'b1;
      word_q   <= 1'b0;
      cnt      <= 4'd0;
      VD_o     <= 16'h0000;
      ROM_ADDR <= 10'd0;
      ROM_RD   <= 1'b0;
      key      <= 32'd0;
      bank     <= 1'b0;
      sec      <= S_LOCKED;
    end else begin
      ROM_RD <= 1'b0;
      key    <= key_nxt;
      bank   <= bank_nxt;
      sec    <= sec_nxt;
      if (bus == B_DECODE && bus_nxt != B_IDLE) begin
        tgt    <= dec_tgt;
        rw_q   <= RW;
        word_q <= !UDS && !LDS;
      end
      if (bus == B_DECODE && bus_nxt == B_READ_ROM) begin
        ROM_RD   <= 1'b1;
        ROM_ADDR <= VA[9:0];
      end
      if (bus_nxt == B_WAIT && bus != B_WAIT) cnt <= WAIT_INIT;
      else if (bus == B_WAIT)                 cnt <= cnt - 4'd1;
      if (bus == B_DECODE && bus_nxt == B_WAIT && RW) VD_o <= reg_rdata;
      // ROM data arrives one cycle after the READ_ROM strobe: first WAIT edge.
      if (bus == B_WAIT && tgt == T_BROM && cnt == WAIT_INIT) VD_o <= ROM_DATA;
    end
  end

endmodule

// File: doc/tmss_bus_ctrl.md
# tmss_bus_ctrl

Bus-cycle sequencer and security controller for the TMSS block on the 68000 side of the console. It decodes CPU accesses to the TMSS register window and the boot-ROM window, and serves them with a fixed-latency DTACK handshake. It sequences reads from the synchronous 1K×16 boot ROM, and runs the "SEGA" key unlock state machine. If the VDP is touched before the key is written on a TMSS-enabled (JAP=1) board, it locks the VDP out.

## Interface
Parameters:
- WAIT_CYCLES, 2, MCLK cycles spent in WAIT before DTACK assertion (legal 1..15)
- KEY, 32'h53454741, unlock key ("SEGA"), high word at A14000, low word at A14002

Ports:
- MCLK  in  1  system clock, all state on rising edge
- SRES  in  1  reset, asynchronous, active-high
- AS, UDS, LDS, RW  in  1 each  68000 strobes, active-low (RW=1 read)
- VA  in  23  CPU word address (byte address = {VA,1'b0})
- VD_i  in  16  CPU write data
- JAP  in  1  1 = TMSS enforced on this board
- ROM_DATA  in  16  boot ROM read data, valid one MCLK after ROM_ADDR/ROM_RD
- VD_o  out  16  read data to CPU, registered
- data_out_en  out  1  drive VD_o onto bus
- DTACK  out  1  active-low acknowledge
- ROM_ADDR  out  10  boot ROM word address, registered
- ROM_RD  out  1  boot ROM read strobe, one-cycle pulse
- ROM_SEL  out  1  1 = boot ROM mapped at 000000 (cartridge CE suppressed)
- VDP_LOCK  out  1  1 = VDP held in lockout
- sec_state  out  2  debug: current security state

## Operation
- Decode, sampled in DECODE only:
  - KEYH: VA==0x50A000
  - KEYL: VA==0x50A001
  - BANK: VA==0x50A080, LDS low (byte A14101)
  - BROM: VA[22:10]==0 and ROM_SEL=1
  - VDP: VA[22:20]==3'b110
  - Any other address is ignored: the FSM returns to IDLE and DTACK is not driven.
- Bus FSM: IDLE -> DECODE -> (READ_ROM for BROM reads) -> WAIT -> ACK -> IDLE.
  - IDLE: leave when AS sampled low.
  - READ_ROM: one cycle; asserts ROM_RD and loads ROM_ADDR=VA[9:0].
  - WAIT: counts WAIT_CYCLES. In a BROM read, VD_o captures ROM_DATA on the first WAIT edge.
  - ACK: DTACK=0; stay while AS low; AS sampled high -> IDLE.
- Reads:
  - KEYH returns key[31:16]; KEYL returns key[15:0].
  - BANK returns {15'b0, bank}.
  - BROM returns ROM data.
  - data_out_en=1 in ACK for reads only.
- Writes commit on the edge entering ACK:
  - KEYH/KEYL require both UDS and LDS low; byte writes to the key are ignored.
  - BANK takes VD_i[0].
- ROM_SEL = JAP & ~bank.
- Security FSM:
  - LOCKED -> UNLOCKED on the commit edge at which key==KEY.
  - UNLOCKED -> LOCKED on any key commit leaving key!=KEY.
  - LOCKED -> LOCKOUT when DECODE sees VDP, JAP=1, and state!=UNLOCKED.
  - LOCKOUT is absorbing until SRES.
  - JAP=0: LOCKOUT is never entered.
  - VDP_LOCK = (state==LOCKOUT).
  - Encoding: LOCKED=0, UNLOCKED=1, LOCKOUT=2.

## Timing
- Reset values: DTACK=1, data_out_en=0, VD_o=0, ROM_ADDR=0, ROM_RD=0, key=0, bank=0, state LOCKED, VDP_LOCK=0, bus FSM IDLE.
  - Hence ROM_SEL=JAP immediately after reset.
- AS low sampled at edge N:
  - DTACK low after edge N+1+WAIT_CYCLES for register accesses.
  - DTACK low after edge N+2+WAIT_CYCLES for BROM reads.
- DTACK returns high on the edge after AS is sampled high.
- AS rising before ACK (aborted cycle): return to IDLE next edge, no commit, DTACK stays 1.
- Back-to-back cycles: AS must be sampled high at least once in ACK before a new cycle is recognised.
- SRES mid-cycle: everything returns to reset values asynchronously. A held AS low after SRES release starts a fresh cycle.
- A bank write that clears ROM_SEL takes effect on the commit edge. The following fetch decodes BROM as not matched.
- Simultaneous events:
  - A key write making key==KEY and a VDP decode cannot coincide, since there is one bus cycle at a time.
  - Lockout is decided with the state as it stands at DECODE.

## Test plan
- Reset, JAP=1, read VA=0x000005 → ROM_RD pulse, ROM_ADDR=5, VD_o=ROM_DATA, DTACK low at N+2+WAIT_CYCLES, ROM_SEL=1.
- Write 0x5345 to 0x50A000, then 0x4741 to 0x50A001 → sec_state 0→1 on the second commit; a VDP access then leaves VDP_LOCK=0.
- JAP=1, no key, access VA=0x600000 → sec_state=2, VDP_LOCK=1. A subsequent correct key write leaves it at 2 until SRES.
- Byte write (UDS high) of 0x53 to 0x50A000 → key unchanged at 0. Write 1 to BANK → ROM_SEL=0, and a read of 0x000000 gets no DTACK.
- AS deasserted in the first WAIT cycle of a key write → no commit, DTACK stays 1, FSM back in IDLE next edge.
- JAP=0 → ROM_SEL=0, a VDP access never locks, and key readback works (0x50A001 returns last written word).
